// File: rtl/seq_chunk_adder.sv
// Multi-cycle add/subtract unit: one CHUNK-bit ripple slice per clock,
// valid/ready on both sides, carry-out and signed-overflow flags.
module seq_chunk_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             Sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Ovf
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IW-1:0] LAST = IW'(NCHUNK - 1);

  if (WIDTH % CHUNK != 0) begin : g_chunk_check
    $error("seq_chunk_adder: WIDTH must be a multiple of CHUNK");
  end

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;
  logic             cout_q;
  logic             ovf_q;
  logic [IW-1:0]    idx_q;

  logic             accept;
  logic             busy;
  logic             last;

  logic [CHUNK-1:0] ch_a;
  logic [CHUNK-1:0] ch_b;
  logic [CHUNK-1:0] ch_s;
  logic             ch_co;
  logic             ch_cmsb;
  logic [WIDTH-1:0] sum_next;

  assign accept = in_valid & in_ready;
  assign busy   = (state_q == BUSY);
  assign last   = busy & (idx_q == LAST);

  // Operands shift down so the active slice always sits in the low bits.
  assign ch_a = a_q[CHUNK-1:0];
  assign ch_b = b_q[CHUNK-1:0];

  always_comb begin
    {ch_co, ch_s} = {1'b0, ch_a} + {1'b0, ch_b}
                  + {{CHUNK{1'b0}}, carry_q};
    ch_cmsb = ch_s[CHUNK-1] ^ ch_a[CHUNK-1] ^ ch_b[CHUNK-1];
  end

  // Result fills from the top; after NCHUNK slices it is fully aligned.
  assign sum_next = (sum_q >> CHUNK)
                  | (WIDTH'(ch_s) << (WIDTH - CHUNK));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = BUSY;
      BUSY: if (last) state_d = DONE;
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (1'b1)
      (state_q == IDLE): in_ready  = 1'b1;
      (state_q == DONE): out_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      idx_q   <= '0;
    end else if (accept) begin
      a_q     <= A;
      b_q     <= Sub ? ~B : B;
      carry_q <= Sub | Cin;
      idx_q   <= '0;
    end else if (busy) begin
      a_q     <= a_q >> CHUNK;
      b_q     <= b_q >> CHUNK;
      sum_q   <= sum_next;
      carry_q <= ch_co;
      idx_q   <= idx_q + 1'b1;
      if (last) begin
        cout_q <= ch_co;
        ovf_q  <= ch_cmsb ^ ch_co;
      end
    end
  end

  assign Sum  = sum_q;
  assign Cout = cout_q;
  assign Ovf  = ovf_q;

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Bench for seq_chunk_adder: three parameterisations against an
// arithmetic reference model, directed and random operations.
module tb_seq_chunk_adder;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [15:0] a_in;
  logic [15:0] b_in;
  logic        cin;
  logic        sub;
  logic        oready;
  logic [2:0]  iv;
  logic [2:0]  ir;
  logic [2:0]  ov;
  logic [2:0]  co;
  logic [2:0]  of;
  logic [15:0] s16;
  logic [3:0]  s4;
  logic [7:0]  s8;

  int checks = 0;
  int errors = 0;
  int wd[3]  = '{16, 4, 8};
  int lat[3] = '{4, 1, 4};

  seq_chunk_adder #(.WIDTH(16), .CHUNK(4)) u16 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv[0]), .in_ready(ir[0]),
    .A(a_in), .B(b_in), .Cin(cin), .Sub(sub),
    .out_valid(ov[0]), .out_ready(oready),
    .Sum(s16), .Cout(co[0]), .Ovf(of[0])
  );

  seq_chunk_adder #(.WIDTH(4), .CHUNK(4)) u4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv[1]), .in_ready(ir[1]),
    .A(a_in[3:0]), .B(b_in[3:0]), .Cin(cin), .Sub(sub),
    .out_valid(ov[1]), .out_ready(oready),
    .Sum(s4), .Cout(co[1]), .Ovf(of[1])
  );

  seq_chunk_adder #(.WIDTH(8), .CHUNK(2)) u8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv[2]), .in_ready(ir[2]),
    .A(a_in[7:0]), .B(b_in[7:0]), .Cin(cin), .Sub(sub),
    .out_valid(ov[2]), .out_ready(oready),
    .Sum(s8), .Cout(co[2]), .Ovf(of[2])
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] get_sum(input int d);
    case (d)
      0:       return s16;
      1:       return {12'h0, s4};
      default: return {8'h0, s8};
    endcase
  endfunction

  // {ovf, cout, sum} from plain integer arithmetic
  function automatic logic [17:0] ref_op(input int w,
      input logic [15:0] a, input logic [15:0] b,
      input logic c, input logic s);
    longint ua, ub, sa, sb, t, st, m, h;
    logic co_e, ov_e;
    m  = (longint'(1) << w) - 1;
    h  = longint'(1) << (w - 1);
    ua = longint'(a) & m;
    ub = longint'(b) & m;
    sa = (ua >= h) ? ua - 2 * h : ua;
    sb = (ub >= h) ? ub - 2 * h : ub;
    if (s) begin
      t    = ua - ub;
      co_e = (ua >= ub);
      st   = sa - sb;
    end else begin
      t    = ua + ub + longint'(c);
      co_e = ((t >> w) & 1) != 0;
      st   = sa + sb + longint'(c);
    end
    ov_e = (st >= h) || (st < -h);
    return {ov_e, co_e, 16'(t & m)};
  endfunction

  task automatic run_op(input int d, input logic [15:0] a,
      input logic [15:0] b, input logic c, input logic s,
      input int hold, input bit press, input bit noisy);
    logic [17:0] e;
    int n;
    e = ref_op(wd[d], a, b, c, s);
    @(negedge clk);
    a_in   = a;
    b_in   = b;
    cin    = c;
    sub    = s;
    oready = 1'b0;
    iv[d]  = 1'b1;
    chk("in_ready", 32'(ir[d]), 1);
    @(posedge clk);
    #1;
    iv[d] = 1'b0;
    a_in  = 16'($urandom);
    b_in  = 16'($urandom);
    cin   = 1'($urandom);
    sub   = 1'($urandom);
    chk("busy_in_ready", 32'(ir[d]), 0);
    n = 0;
    while (!ov[d] && n < 40) begin
      if (noisy) oready = 1'($urandom);
      @(posedge clk);
      #1;
      n++;
    end
    oready = 1'b0;
    chk("latency", n, lat[d]);
    for (int i = 0; i < hold; i++) begin
      if (press) begin
        iv[d] = 1'b1;
        a_in  = 16'($urandom);
        b_in  = 16'($urandom);
      end
      @(posedge clk);
      #1;
      if (press) begin
        chk("bp_in_ready", 32'(ir[d]), 0);
        chk("bp_sum", 32'(get_sum(d)), 32'(e[15:0]));
        chk("bp_cout", 32'(co[d]), 32'(e[16]));
      end
    end
    iv[d] = 1'b0;
    chk("hold_valid", 32'(ov[d]), 1);
    chk("sum", 32'(get_sum(d)), 32'(e[15:0]));
    chk("cout", 32'(co[d]), 32'(e[16]));
    chk("ovf", 32'(of[d]), 32'(e[17]));
    oready = 1'b1;
    @(posedge clk);
    #1;
    chk("drop_valid", 32'(ov[d]), 0);
    chk("idle_ready", 32'(ir[d]), 1);
    oready = 1'b0;
  endtask

  logic [15:0] va[6] = '{16'h0001, 16'h0005, 16'hFFFF,
                         16'h7FFF, 16'h0005, 16'h8000};
  logic [15:0] vb[6] = '{16'h0002, 16'h0005, 16'h0001,
                         16'h0001, 16'h0007, 16'h0001};
  logic        vc[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
  logic        vs[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
  logic [15:0] wa[3] = '{16'h1, 16'h5, 16'hF};
  logic [15:0] wb[3] = '{16'h2, 16'h5, 16'h1};

  initial begin
    int n;
    rst_n  = 1'b0;
    iv     = '0;
    oready = 1'b0;
    a_in   = '0;
    b_in   = '0;
    cin    = 1'b0;
    sub    = 1'b0;
    #2;
    for (int d = 0; d < 3; d++) begin
      chk("rst_in_ready", 32'(ir[d]), 1);
      chk("rst_out_valid", 32'(ov[d]), 0);
      chk("rst_sum", 32'(get_sum(d)), 0);
      chk("rst_cout", 32'(co[d]), 0);
      chk("rst_ovf", 32'(of[d]), 0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++)
      run_op(0, va[i], vb[i], vc[i], vs[i], 0, 1'b0, 1'b0);

    run_op(0, 16'h1234, 16'h4321, 1'b0, 1'b0, 6, 1'b1, 1'b0);

    @(negedge clk);
    a_in  = 16'h1234;
    b_in  = 16'h1111;
    cin   = 1'b0;
    sub   = 1'b0;
    iv[0] = 1'b1;
    @(posedge clk);
    #1;
    iv[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_sum", 32'(s16), 0);
    chk("mid_rst_cout", 32'(co[0]), 0);
    chk("mid_rst_ovf", 32'(of[0]), 0);
    chk("mid_rst_valid", 32'(ov[0]), 0);
    chk("mid_rst_ready", 32'(ir[0]), 1);
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (ov[0]) n++;
    end
    chk("stale_valid", n, 0);
    run_op(0, 16'h1234, 16'h1111, 1'b0, 1'b0, 0, 1'b0, 1'b0);

    for (int i = 0; i < 3; i++)
      run_op(1, wa[i], wb[i], 1'b0, 1'b0, 0, 1'b0, 1'b0);
    for (int i = 0; i < 50; i++)
      run_op(1, 16'($urandom), 16'($urandom), 1'($urandom),
             1'($urandom), $urandom_range(0, 2), 1'b0, 1'b1);

    for (int i = 0; i < 1000; i++)
      run_op(2, 16'($urandom), 16'($urandom), 1'($urandom),
             1'($urandom), $urandom_range(0, 3), 1'b0, 1'b1);

    for (int i = 0; i < 100; i++)
      run_op(0, 16'($urandom), 16'($urandom), 1'($urandom),
             1'($urandom), $urandom_range(0, 2), 1'($urandom), 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
